// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one slow_memory line port between I-cache and D-cache.
// Serialises transactions, latches the winner's command and routes the response back to its owner.
module mem_port_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    state_t              state_r, state_s;
    logic                last_grant_r, last_grant_s;
    logic                owner_r, owner_s;
    logic                mem_read_r, mem_read_s;
    logic                mem_write_r, mem_write_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic [DATA_W-1:0]   i_rdata_r, i_rdata_s;
    logic [DATA_W-1:0]   d_rdata_r, d_rdata_s;
    logic                i_ready_r, i_ready_s;
    logic                d_ready_r, d_ready_s;
    logic [15:0]         conflict_cnt_r, conflict_cnt_s;

    logic                req_i_s, req_d_s, both_s, grant_d_s;

    assign req_i_s = i_read | i_write;
    assign req_d_s = d_read | d_write;
    assign both_s  = req_i_s & req_d_s;

    // Arbitration decision: single requester wins outright, conflicts by priority or round-robin
    always_comb begin
        if (both_s) begin
            if (FIXED_PRIO != 0) begin
                grant_d_s = 1'b1;
            end else begin
                grant_d_s = (last_grant_r == SIDE_I);
            end
        end else begin
            grant_d_s = req_d_s;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DONE always lasts exactly one cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_i_s | req_d_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; write wins when a side asserts read and write together
    always_comb begin
        last_grant_s   = last_grant_r;
        owner_s        = owner_r;
        mem_read_s     = mem_read_r;
        mem_write_s    = mem_write_r;
        mem_addr_s     = mem_addr_r;
        mem_wdata_s    = mem_wdata_r;
        i_rdata_s      = i_rdata_r;
        d_rdata_s      = d_rdata_r;
        i_ready_s      = i_ready_r;
        d_ready_s      = d_ready_r;
        conflict_cnt_s = conflict_cnt_r;
        case (state_r)
            ST_IDLE: begin
                i_ready_s = 1'b0;
                d_ready_s = 1'b0;
                if (req_i_s | req_d_s) begin
                    owner_s = grant_d_s;
                    if (grant_d_s) begin
                        mem_addr_s  = d_addr;
                        mem_wdata_s = d_wdata;
                        mem_write_s = d_write;
                        mem_read_s  = d_read & ~d_write;
                    end else begin
                        mem_addr_s  = i_addr;
                        mem_wdata_s = i_wdata;
                        mem_write_s = i_write;
                        mem_read_s  = i_read & ~i_write;
                    end
                    if (both_s && (FIXED_PRIO == 0) && (conflict_cnt_r != 16'hFFFF)) begin
                        conflict_cnt_s = conflict_cnt_r + 16'd1;
                    end else begin
                        conflict_cnt_s = conflict_cnt_r;
                    end
                end else begin
                    mem_read_s  = 1'b0;
                    mem_write_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    mem_read_s   = 1'b0;
                    mem_write_s  = 1'b0;
                    last_grant_s = owner_r;
                    if (owner_r == SIDE_D) begin
                        d_rdata_s = mem_rdata;
                        d_ready_s = 1'b1;
                    end else begin
                        i_rdata_s = mem_rdata;
                        i_ready_s = 1'b1;
                    end
                end else begin
                    mem_read_s  = mem_read_r;
                    mem_write_s = mem_write_r;
                end
            end
            ST_DONE: begin
                i_ready_s = 1'b0;
                d_ready_s = 1'b0;
            end
            default: begin
                mem_read_s  = 1'b0;
                mem_write_s = 1'b0;
                i_ready_s   = 1'b0;
                d_ready_s   = 1'b0;
            end
        endcase
    end

    // Output and bookkeeping registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r   <= SIDE_I;
            owner_r        <= SIDE_I;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_addr_r     <= {ADDR_W{1'b0}};
            mem_wdata_r    <= {DATA_W{1'b0}};
            i_rdata_r      <= {DATA_W{1'b0}};
            d_rdata_r      <= {DATA_W{1'b0}};
            i_ready_r      <= 1'b0;
            d_ready_r      <= 1'b0;
            conflict_cnt_r <= 16'd0;
        end else begin
            last_grant_r   <= last_grant_s;
            owner_r        <= owner_s;
            mem_read_r     <= mem_read_s;
            mem_write_r    <= mem_write_s;
            mem_addr_r     <= mem_addr_s;
            mem_wdata_r    <= mem_wdata_s;
            i_rdata_r      <= i_rdata_s;
            d_rdata_r      <= d_rdata_s;
            i_ready_r      <= i_ready_s;
            d_ready_r      <= d_ready_s;
            conflict_cnt_r <= conflict_cnt_s;
        end
    end

    assign mem_read     = mem_read_r;
    assign mem_write    = mem_write_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign i_rdata      = i_rdata_r;
    assign d_rdata      = d_rdata_r;
    assign i_ready      = i_ready_r;
    assign d_ready      = d_ready_r;
    assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: u0 is round-robin, u1 is fixed D priority.
// A transaction-level model predicts owner, command, conflict count and returned data.
module tb_mem_port_arbiter;

    logic         clk;
    logic         rst_n;
    logic         p_read  [2][2];
    logic         p_write [2][2];
    logic [27:0]  p_addr  [2][2];
    logic [127:0] p_wdata [2][2];
    logic [127:0] p_rdata [2][2];
    logic         p_ready [2][2];
    logic         m_read  [2];
    logic         m_write [2];
    logic [27:0]  m_addr  [2];
    logic [127:0] m_wdata [2];
    logic [127:0] m_rdata [2];
    logic         m_ready [2];
    logic [15:0]  cc      [2];

    int checks = 0;
    int failures = 0;

    // Requester-side view of the pending requests (index 0 = I, 1 = D)
    bit           pend [2];
    bit           rd   [2];
    bit           wr   [2];
    logic [27:0]  raddr[2];
    logic [127:0] rwd  [2];
    // Model state per DUT
    int           last [2];
    int           cnt  [2];
    logic [127:0] e_rdata [2][2];

    mem_port_arbiter #(.ADDR_W(28), .DATA_W(128), .FIXED_PRIO(0)) u0 (
        .clk(clk), .rst_n(rst_n),
        .i_read(p_read[0][0]), .i_write(p_write[0][0]), .i_addr(p_addr[0][0]),
        .i_wdata(p_wdata[0][0]), .i_rdata(p_rdata[0][0]), .i_ready(p_ready[0][0]),
        .d_read(p_read[0][1]), .d_write(p_write[0][1]), .d_addr(p_addr[0][1]),
        .d_wdata(p_wdata[0][1]), .d_rdata(p_rdata[0][1]), .d_ready(p_ready[0][1]),
        .mem_read(m_read[0]), .mem_write(m_write[0]), .mem_addr(m_addr[0]),
        .mem_wdata(m_wdata[0]), .mem_rdata(m_rdata[0]), .mem_ready(m_ready[0]),
        .conflict_cnt(cc[0])
    );

    mem_port_arbiter #(.ADDR_W(28), .DATA_W(128), .FIXED_PRIO(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .i_read(p_read[1][0]), .i_write(p_write[1][0]), .i_addr(p_addr[1][0]),
        .i_wdata(p_wdata[1][0]), .i_rdata(p_rdata[1][0]), .i_ready(p_ready[1][0]),
        .d_read(p_read[1][1]), .d_write(p_write[1][1]), .d_addr(p_addr[1][1]),
        .d_wdata(p_wdata[1][1]), .d_rdata(p_rdata[1][1]), .d_ready(p_ready[1][1]),
        .mem_read(m_read[1]), .mem_write(m_write[1]), .mem_addr(m_addr[1]),
        .mem_wdata(m_wdata[1]), .mem_rdata(m_rdata[1]), .mem_ready(m_ready[1]),
        .conflict_cnt(cc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input int u);
        for (int s = 0; s < 2; s++) begin
            p_read[u][s]  = pend[s] && rd[s];
            p_write[u][s] = pend[s] && wr[s];
            p_addr[u][s]  = raddr[s];
            p_wdata[u][s] = rwd[s];
        end
    endtask

    task automatic set_req(input int s, input bit r, input bit w, input logic [27:0] a,
                           input logic [127:0] d);
        pend[s] = 1'b1;
        rd[s] = r;
        wr[s] = w;
        raddr[s] = a;
        rwd[s] = d;
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            last[u] = 0;
            cnt[u] = 0;
            e_rdata[u][0] = 128'd0;
            e_rdata[u][1] = 128'd0;
        end
    endtask

    // One complete transaction on DUT u, called at a negedge with the arbiter idle and requests driven
    task automatic serve(input int u, input int lat, input logic [127:0] resp);
        int own;
        int oth;
        int t;
        bit er;
        bit ew;
        logic [27:0] ea;
        logic [127:0] ewd;
        if (pend[0] && pend[1]) begin
            own = (u == 1) ? 1 : ((last[u] == 0) ? 1 : 0);
            if (u == 0 && cnt[u] < 65535) cnt[u]++;
        end else begin
            own = pend[1] ? 1 : 0;
        end
        oth = 1 - own;
        ew = wr[own];
        er = rd[own] && !wr[own];
        ea = raddr[own];
        ewd = rwd[own];
        t = 0;
        while (!(m_read[u] || m_write[u]) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("grant_seen", 128'(m_read[u] | m_write[u]), 128'd1);
        chk("grant_latency", 128'(t), 128'd1);
        chk("mem_write", 128'(m_write[u]), 128'(ew));
        chk("mem_read", 128'(m_read[u]), 128'(er));
        chk("mem_addr", 128'(m_addr[u]), 128'(ea));
        chk("mem_wdata", m_wdata[u], ewd);
        chk("conflict_cnt", 128'(cc[u]), 128'(cnt[u]));
        // Requester changes its inputs mid-transaction; latched copy must hold
        p_addr[u][own]  = raddr[own] + 28'h10;
        p_wdata[u][own] = ~rwd[own];
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("busy_addr_hold", 128'(m_addr[u]), 128'(ea));
            chk("busy_read_hold", 128'(m_read[u]), 128'(er));
            chk("busy_no_ready", 128'(p_ready[u][own]), 128'd0);
        end
        m_ready[u] = 1'b1;
        m_rdata[u] = resp;
        @(negedge clk);
        m_ready[u] = 1'b0;
        m_rdata[u] = {$urandom, $urandom, $urandom, $urandom};
        e_rdata[u][own] = resp;
        last[u] = own;
        chk("owner_ready", 128'(p_ready[u][own]), 128'd1);
        chk("other_ready", 128'(p_ready[u][oth]), 128'd0);
        chk("owner_rdata", p_rdata[u][own], e_rdata[u][own]);
        chk("other_rdata", p_rdata[u][oth], e_rdata[u][oth]);
        chk("done_mem_read", 128'(m_read[u]), 128'd0);
        chk("done_mem_write", 128'(m_write[u]), 128'd0);
        pend[own] = 1'b0;
        apply(u);
        @(negedge clk);
        chk("ready_pulse_end_i", 128'(p_ready[u][0]), 128'd0);
        chk("ready_pulse_end_d", 128'(p_ready[u][1]), 128'd0);
        chk("idle_no_cmd", 128'(m_read[u] | m_write[u]), 128'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            for (int s = 0; s < 2; s++) begin
                p_read[u][s] = 1'b0;
                p_write[u][s] = 1'b0;
                p_addr[u][s] = 28'd0;
                p_wdata[u][s] = 128'd0;
            end
            m_ready[u] = 1'b0;
            m_rdata[u] = 128'd0;
        end
        for (int s = 0; s < 2; s++) begin
            pend[s] = 1'b0;
            rd[s] = 1'b0;
            wr[s] = 1'b0;
            raddr[s] = 28'd0;
            rwd[s] = 128'd0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_mem_read", 128'(m_read[u]), 128'd0);
            chk("rst_mem_write", 128'(m_write[u]), 128'd0);
            chk("rst_mem_addr", 128'(m_addr[u]), 128'd0);
            chk("rst_i_rdata", p_rdata[u][0], 128'd0);
            chk("rst_d_ready", 128'(p_ready[u][1]), 128'd0);
            chk("rst_conflict", 128'(cc[u]), 128'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // I-only read, 5-cycle memory
        set_req(0, 1'b1, 1'b0, 28'h0000010, 128'd0);
        apply(0);
        serve(0, 5, {16{8'hA5}});

        // Simultaneous I read / D write under round-robin: D first, then I
        set_req(0, 1'b1, 1'b0, 28'h0000010, 128'd0);
        set_req(1, 1'b0, 1'b1, 28'h0000020, 128'h1234);
        apply(0);
        serve(0, 3, 128'h0BAD);
        serve(0, 2, 128'h600D);
        chk("rr_conflict_total", 128'(cc[0]), 128'd1);

        // Fixed priority: D wins four conflicts in a row, counter stays 0
        set_req(0, 1'b1, 1'b0, 28'h0000010, 128'd0);
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b0, 1'b1, 28'h0000020, 128'h1234);
            apply(1);
            serve(1, 2, 128'(k + 100));
        end
        serve(1, 2, 128'h77);
        chk("fp_conflict_total", 128'(cc[1]), 128'd0);

        // Continuous contention: six transactions alternating D, I, D, I, D, I
        for (int k = 0; k < 6; k++) begin
            for (int s = 0; s < 2; s++) begin
                if (!pend[s]) set_req(s, ($urandom % 2) == 0, ($urandom % 2) == 0 ? 1'b0 : 1'b1,
                                      28'($urandom), {$urandom, $urandom, $urandom, $urandom});
                if (!rd[s] && !wr[s]) rd[s] = 1'b1;
            end
            apply(0);
            chk("alternate_owner", 128'(last[0] == 0 ? 1 : 0), 128'((k % 2) == 0 ? 1 : 0));
            serve(0, int'($urandom_range(1, 4)), {$urandom, $urandom, $urandom, $urandom});
        end

        // Randomised traffic on the round-robin instance
        for (int k = 0; k < 30; k++) begin
            for (int s = 0; s < 2; s++) begin
                if (!pend[s] && ($urandom % 2) == 0) begin
                    int op;
                    op = int'($urandom % 3);
                    set_req(s, op != 1, op != 0, 28'($urandom), {$urandom, $urandom, $urandom, $urandom});
                end
            end
            if (!pend[0] && !pend[1]) set_req(int'($urandom % 2), 1'b1, 1'b0, 28'($urandom), 128'd0);
            apply(0);
            serve(0, int'($urandom_range(1, 6)), {$urandom, $urandom, $urandom, $urandom});
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        apply(0);
        @(negedge clk);

        // Reset two cycles into BUSY abandons the transaction
        set_req(0, 1'b1, 1'b0, 28'h0000040, 128'd0);
        apply(0);
        @(negedge clk);
        chk("pre_reset_busy", 128'(m_read[0]), 128'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_mem_read", 128'(m_read[0]), 128'd0);
        chk("async_rst_mem_addr", 128'(m_addr[0]), 128'd0);
        chk("async_rst_i_rdata", p_rdata[0][0], 128'd0);
        chk("async_rst_d_rdata", p_rdata[0][1], 128'd0);
        chk("async_rst_conflict", 128'(cc[0]), 128'd0);
        model_reset();
        pend[0] = 1'b0;
        apply(0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            m_ready[0] = 1'b0;
            chk("no_stale_ready_i", 128'(p_ready[0][0]), 128'd0);
            chk("no_stale_ready_d", 128'(p_ready[0][1]), 128'd0);
        end
        set_req(1, 1'b1, 1'b0, 28'h0000050, 128'd0);
        apply(0);
        serve(0, 3, 128'hFEED_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
